// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_pipe
//  Description : ID/EX pipeline register with stall, flush (bubble) and a
//                sticky HALTED state entered when a dump/err reaches EX.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_pipe #(
    parameter int DATA_W      = 16,
    parameter bit HALT_ON_ERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [15:0]       id_instr,
    input  logic [DATA_W-1:0] id_pc_inc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [2:0]        id_alu_src,
    input  logic [1:0]        id_reg_dst,
    input  logic [4:0]        id_hasAB,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_invA,
    input  logic              id_invB,
    input  logic              id_Cin,
    input  logic              id_dump,
    input  logic              id_err,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc_inc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [2:0]        ex_alu_src,
    output logic [4:0]        ex_hasAB,
    output logic [2:0]        ex_wr_reg,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_invA,
    output logic              ex_invB,
    output logic              ex_Cin,
    output logic              ex_dump,
    output logic              ex_err,
    output logic              halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_load;
    logic       w_halt_req;
    logic [2:0] w_wr_reg;
    logic       w_unused_instr;

    // Only the three register-index fields of the instruction are consumed here.
    assign w_unused_instr = ^{id_instr[15:11], id_instr[1:0]};

    always_comb begin
        w_wr_reg = 3'b111;
        case (id_reg_dst)
            2'd0:    w_wr_reg = id_instr[4:2];
            2'd1:    w_wr_reg = id_instr[7:5];
            2'd2:    w_wr_reg = id_instr[10:8];
            default: w_wr_reg = 3'b111;
        endcase
    end

    assign w_load     = (r_state == ST_RUN) && !flush && !stall;
    assign w_halt_req = id_valid && (id_dump || (HALT_ON_ERR && id_err));

    always_comb begin
        w_state_nxt = r_state;
        if (w_load && w_halt_req) begin
            w_state_nxt = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign halted = (r_state == ST_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_pc_inc     <= '0;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_alu_src    <= 3'b000;
            ex_hasAB      <= 5'b00000;
            ex_wr_reg     <= 3'b000;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_invA       <= 1'b0;
            ex_invB       <= 1'b0;
            ex_Cin        <= 1'b0;
            ex_dump       <= 1'b0;
            ex_err        <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (flush) begin
                // Bubble: kill every side-effecting bit, leave the payload alone.
                ex_valid     <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_dump      <= 1'b0;
                ex_err       <= 1'b0;
            end else if (!stall) begin
                ex_valid      <= id_valid;
                ex_pc_inc     <= id_pc_inc;
                ex_rd1        <= id_rd1;
                ex_rd2        <= id_rd2;
                ex_imm        <= id_imm;
                ex_alu_src    <= id_alu_src;
                ex_hasAB      <= id_hasAB;
                ex_wr_reg     <= w_wr_reg;
                ex_mem_write  <= id_mem_write & id_valid;
                ex_reg_write  <= id_reg_write & id_valid;
                ex_mem_to_reg <= id_mem_to_reg;
                ex_invA       <= id_invA;
                ex_invB       <= id_invB;
                ex_Cin        <= id_Cin;
                ex_dump       <= id_dump & id_valid;
                ex_err        <= id_err & id_valid;
            end
        end
    end

endmodule
`default_nettype wire
